serial_mag_comparator_ctrl: RTL and testbench
=============================================

Name: serial_mag_comparator_ctrl

Overview:
Sequences a single internal 1-bit compare slice (gt = a&~b, lt = ~a&b, eq = ~(a^b)) across two WIDTH-bit operands, MSB first, to produce a magnitude-compare result. It accepts operands over a valid/ready input handshake and returns a one-hot gt/eq/lt result over a valid/ready output handshake. It is the area-lean multi-bit compare used where a parallel comparator is not warranted.

Parameters:
WIDTH, 8, operand width in bits; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands a/b valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts result.
gt  output  1  A > B.
eq  output  1  A == B.
lt  output  1  A < B.
busy  output  1  high in SHIFT state.

Behaviour:
- Reset: on any edge with rst=1, state goes to IDLE, shift registers and counter clear, and gt/eq/lt/out_valid/busy go to 0. in_ready reads 1 from the first cycle after rst deasserts.
- rst has priority over every other event. Asserting rst mid-compare aborts the operation: IDLE on the next edge, out_valid is never raised for the aborted operation, and no residual state survives.
- States:
  - IDLE: in_ready=1. When in_valid and in_ready, latch a/b into shift registers, load bit counter = WIDTH-1, clear the decided flag, and go to SHIFT. a/b are sampled only on the accept edge; later changes are ignored.
  - SHIFT: busy=1, in_ready=0. Each cycle, apply the slice to the shift-register MSBs, then shift both registers left by 1 and decrement the counter.
    - On the first bit where slice gt or lt is 1: record it and set the decided flag. Later bits cannot change a decided result.
    - If the counter is 0 and nothing is decided: result is eq.
    - Go to DONE after the deciding bit (see Optional Feature) or after the counter-0 bit.
  - DONE: out_valid=1. gt/eq/lt are registered, exactly one is high, and they are held stable while out_ready=0. in_ready=0, so in_valid is ignored. When out_ready=1, go to IDLE on the next edge; gt/eq/lt/out_valid clear to 0 on that edge.
- There is no overlap between DONE and IDLE. A new operand is accepted no earlier than the cycle after the result handoff (one-cycle bubble).
- Latency: handshake in cycle 0, first SHIFT in cycle 1. Let d = number of bits examined = WIDTH - p, where p is the index of the most-significant differing bit. out_valid rises in cycle d+1 with early termination, and always in cycle WIDTH+1 without it or when operands are equal.
- Counter width is clog2(WIDTH)+1. WIDTH=1 needs no special case: one SHIFT cycle, out_valid in cycle 2.
- out_valid is never high in the same cycle as in_ready or busy.

Optional Feature:
Macro: SERIAL_CMP_EARLY_TERM_EN.
- Defined: SHIFT goes to DONE on the edge after the first differing bit, giving data-dependent latency d+1.
- Undefined: SHIFT always runs all WIDTH bits, giving fixed latency WIDTH+1. The result is identical in both builds; only timing differs.

Test Plan:
1. Hold rst=1 for 2 cycles, then release -> in_ready=1 next cycle; out_valid, gt, eq, lt, busy all 0.
2. WIDTH=8, a=8'hA5, b=8'hA5 accepted in cycle 0 -> busy high cycles 1-8; cycle 9 out_valid=1, eq=1, gt=lt=0 (both builds).
3. a=8'h80, b=8'h7F -> gt=1. out_valid in cycle 2 with SERIAL_CMP_EARLY_TERM_EN, cycle 9 without.
4. a=8'h12, b=8'h13 (differ only at bit 0) -> lt=1, out_valid in cycle 9 in both builds. Also a=8'h00, b=8'hFF -> lt=1, cycle 2 early-term build.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> gt/eq/lt stable, in_ready=0, in_valid pulses ignored. Then raise out_ready=1 -> next cycle IDLE, in_ready=1, results cleared to 0.
6. Start a=8'h01, b=8'h02 and pulse rst in cycle 3 -> IDLE next edge, no out_valid ever for that operation. A following compare of a=8'h03, b=8'h01 returns gt=1 with correct latency.

Source files
------------

// File: rtl/serial_mag_comparator_ctrl_if.sv
// Handshake bundle for serial_mag_comparator_ctrl: operand input and one-hot result output.
// The slave modport is the comparator; the master modport is the environment around it.
interface serial_mag_comparator_ctrl_if #(
  parameter int WIDTH = 8
);
  // Both channels use valid/ready. A transfer happens on a rising edge where valid
  // and ready are both high. Once valid is raised, the sender holds valid and its data
  // steady until that transfer. Ready may change without regard to valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gt, eq, lt, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gt, eq, lt, busy
  );
endinterface

// File: rtl/serial_mag_comparator_ctrl.sv
// Bit-serial MSB-first magnitude comparator: one 1-bit slice is stepped across WIDTH bits.
// Optional macro SERIAL_CMP_EARLY_TERM_EN ends the scan at the first differing bit.
module serial_mag_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  serial_mag_comparator_ctrl_if.slave     bus,
  output logic [1:0]                      state_dbg
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic             dec_gt;
  logic             dec_lt;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;

  logic slice_gt;
  logic slice_lt;
  logic new_gt;
  logic new_lt;
  logic new_dec;
  logic last_bit;
  logic finish;

  // Only the first differing bit may set the result; later bits are masked by decided.
  always_comb begin
    slice_gt = sh_a[WIDTH-1] & ~sh_b[WIDTH-1];
    slice_lt = ~sh_a[WIDTH-1] & sh_b[WIDTH-1];
    new_gt   = dec_gt | (~decided & slice_gt);
    new_lt   = dec_lt | (~decided & slice_lt);
    new_dec  = decided | slice_gt | slice_lt;
    last_bit = (cnt == '0);
`ifdef SERIAL_CMP_EARLY_TERM_EN
    finish   = last_bit | new_dec;
`else
    finish   = last_bit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      dec_lt  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh_a    <= bus.a;
            sh_b    <= bus.b;
            cnt     <= CW'(WIDTH - 1);
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            dec_lt  <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sh_a    <= sh_a << 1;
          sh_b    <= sh_b << 1;
          cnt     <= cnt - CW'(1);
          decided <= new_dec;
          dec_gt  <= new_gt;
          dec_lt  <= new_lt;
          if (finish) begin
            gt_q  <= new_gt;
            lt_q  <= new_lt;
            eq_q  <= ~new_dec;
            state <= DONE;
          end
        end
        DONE: begin
          // Results are held until the consumer takes them, then cleared with the handoff.
          if (bus.out_ready) begin
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == SHIFT);
  assign bus.out_valid = (state == DONE);
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Bench for serial_mag_comparator_ctrl: directed and random compares against an arithmetic model,
// latency, backpressure, reset abort and back-to-back handoff.
module tb_serial_mag_comparator_ctrl;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_checks;
  int         n_pass;
  logic [2:0] exp_q[$];

  serial_mag_comparator_ctrl_if #(.WIDTH(W)) bus ();

  serial_mag_comparator_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x > y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  // Cycle (relative to the accept cycle 0) in which out_valid is expected.
  function automatic int model_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_TERM_EN
    for (int i = W - 1; i >= 0; i--)
      if (x[i] != y[i]) return (W - i) + 1;
`endif
    return W + 1;
  endfunction

  // ---------------- driver: one full compare, called at a negedge ----------------
  task automatic run_compare(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    logic [2:0] exp_r;
    int lat;
    int cyc;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b want 1 (a=%h b=%h)", bus.in_ready, x, y);
    else n_pass++;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    exp_q.push_back(model_result(x, y));
    lat = model_latency(x, y);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < W + 6) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL shift_flags: cyc=%0d busy=%b in_ready=%b want 1/0", cyc, bus.busy, bus.in_ready);
      else n_pass++;
      @(negedge clk);
      cyc++;
    end
    exp_r = exp_q.pop_front();
    n_checks++;
    if (cyc !== lat) $display("FAIL latency: a=%h b=%h got cycle %0d want %0d", x, y, cyc, lat);
    else n_pass++;
    n_checks++;
    if ({bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy, bus.in_ready} !== {1'b1, exp_r, 2'b00})
      $display("FAIL result: a=%h b=%h got v=%b gel=%b%b%b busy=%b rdy=%b want v=1 gel=%b busy=0 rdy=0",
               x, y, bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy, bus.in_ready, exp_r);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.gt, bus.eq, bus.lt} !== {2'b10, exp_r})
        $display("FAIL hold: cycle %0d got v=%b rdy=%b gel=%b%b%b want v=1 rdy=0 gel=%b",
                 i, bus.out_valid, bus.in_ready, bus.gt, bus.eq, bus.lt, exp_r);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.gt, bus.eq, bus.lt, bus.busy} !== 6'b010000)
      $display("FAIL handoff: got v=%b rdy=%b gel=%b%b%b busy=%b want v=0 rdy=1 gel=000 busy=0",
               bus.out_valid, bus.in_ready, bus.gt, bus.eq, bus.lt, bus.busy);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy} !== 6'b100000)
      $display("FAIL reset: got rdy=%b v=%b gel=%b%b%b busy=%b want rdy=1 rest 0",
               bus.in_ready, bus.out_valid, bus.gt, bus.eq, bus.lt, bus.busy);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_compare(8'hA5, 8'hA5, 0);
    run_compare(8'h80, 8'h7F, 0);
    run_compare(8'h12, 8'h13, 0);
    run_compare(8'h00, 8'hFF, 0);
    run_compare(8'hFF, 8'hFE, 0);
    run_compare(8'h00, 8'h00, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : W'($urandom);
      run_compare(x, y, 0);
    end
  endtask

  task automatic test_backpressure();
    run_compare(8'h3C, 8'h3B, 5);
    run_compare(8'h55, 8'h55, 3);
  endtask

  task automatic test_reset_abort();
    int seen;
    bus.a = 8'h01;
    bus.b = 8'h02;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.gt, bus.eq, bus.lt} !== 6'b100000)
      $display("FAIL abort_idle: got rdy=%b busy=%b v=%b gel=%b%b%b want rdy=1 rest 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.gt, bus.eq, bus.lt);
    else n_pass++;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_quiet: activity in %0d cycles want 0", seen);
    else n_pass++;
    run_compare(8'h03, 8'h01, 0);
  endtask

  task automatic test_back_to_back();
    run_compare(8'h40, 8'h41, 0);
    run_compare(8'hC0, 8'h0C, 1);
    run_compare(8'h7E, 8'h7E, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
